axis_sample_source: RTL and testbench

Streaming sample packetizer that drives the AXI-Stream input of the FIR filter chain. Accepts one sample per `sample_valid_in` strobe from an ADC/sample front end, buffers samples in a small FIFO, and presents them as an AXI-Stream master with `tlast` marking every `FRAME_LEN`-th accepted sample. Honours `m00_axis_tready` backpressure and reports drops when the buffer overflows.

---
 rtl/axis_sample_source.sv | 102 ++++++++++
 tb/tb_axis_sample_source.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_source.sv
// Sample packetizer: buffers strobed samples in a FIFO and emits them as an AXI-Stream
// master with tlast every FRAME_LEN accepted samples. Define AXIS_SAMPLE_SOURCE_OVF_CNT_EN for a drop counter.
module axis_sample_source #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH             = 16,
  parameter int FRAME_LEN              = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_in,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]     sample_in,
  input  logic                                  sample_valid_in,
  input  logic                                  enable_in,
  input  logic                                  clr_ovf_in,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level_out,
  output logic                                  overflow_out,
  output logic [15:0]                           ovf_count_out
);

  localparam int DW    = C_M00_AXIS_TDATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int FC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [DW:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [FC_W-1:0]  frame_cnt;
  logic             frame_end;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             drop;
  logic [DW:0]      head;

  always_comb begin
    frame_end = (frame_cnt == FC_W'(FRAME_LEN - 1));
    push_req  = sample_valid_in && enable_in;
    pop       = m00_axis_tvalid && m00_axis_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok   = push_req && ((level < LVL_W'(FIFO_DEPTH)) || pop);
    drop      = push_req && !push_ok;
    head      = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {frame_end, sample_in};
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        frame_cnt <= frame_end ? '0 : frame_cnt + FC_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in)          overflow_out <= 1'b0;
    else if (clr_ovf_in) overflow_out <= 1'b0;
    else if (drop)       overflow_out <= 1'b1;
  end

`ifdef AXIS_SAMPLE_SOURCE_OVF_CNT_EN
  logic [15:0] ovf_cnt;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in)                           ovf_cnt <= '0;
    else if (clr_ovf_in)                  ovf_cnt <= '0;
    else if (drop && (ovf_cnt != '1))     ovf_cnt <= ovf_cnt + 16'd1;
  end

  assign ovf_count_out = ovf_cnt;
`else
  assign ovf_count_out = '0;
`endif

  // Head entry is masked while empty so the reset/idle view of tdata/tlast is zero.
  assign m00_axis_tvalid = (level != '0);
  assign m00_axis_tdata  = m00_axis_tvalid ? head[DW-1:0] : '0;
  assign m00_axis_tlast  = m00_axis_tvalid ? head[DW] : 1'b0;
  assign m00_axis_tstrb  = '1;
  assign fifo_level_out  = level;

endmodule

// File: tb/tb_axis_sample_source.sv
// Randomized and directed bench for axis_sample_source (FIFO_DEPTH=16, FRAME_LEN=4),
// compared every cycle against a queue-based reference model.
module tb_axis_sample_source;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int FLEN  = 4;

  logic          clk = 1'b0;
  logic          rst_in;
  logic [DW-1:0] sample_in;
  logic          sample_valid_in;
  logic          enable_in;
  logic          clr_ovf_in;
  logic          m00_axis_tready;
  logic          m00_axis_tvalid;
  logic          m00_axis_tlast;
  logic [DW-1:0] m00_axis_tdata;
  logic [3:0]    m00_axis_tstrb;
  logic [4:0]    fifo_level_out;
  logic          overflow_out;
  logic [15:0]   ovf_count_out;

  axis_sample_source #(
    .C_M00_AXIS_TDATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FRAME_LEN(FLEN)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .sample_in(sample_in),
    .sample_valid_in(sample_valid_in),
    .enable_in(enable_in),
    .clr_ovf_in(clr_ovf_in),
    .m00_axis_tready(m00_axis_tready),
    .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tlast(m00_axis_tlast),
    .m00_axis_tdata(m00_axis_tdata),
    .m00_axis_tstrb(m00_axis_tstrb),
    .fifo_level_out(fifo_level_out),
    .overflow_out(overflow_out),
    .ovf_count_out(ovf_count_out)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: queue of {last, data}, frame position, sticky flag, drop tally.
  logic [DW:0] mq[$];
  int unsigned m_pos = 0;
  logic        m_ovf = 1'b0;
  int unsigned m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pos = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic compare_all(input string tag);
    logic [DW:0] hd;
    int unsigned exp_cnt;
    hd = (mq.size() != 0) ? mq[0] : '0;
`ifdef AXIS_SAMPLE_SOURCE_OVF_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check({tag, ".tvalid"}, 64'(m00_axis_tvalid), 64'(mq.size() != 0));
    check({tag, ".tdata"},  64'(m00_axis_tdata),  64'(hd[DW-1:0]));
    check({tag, ".tlast"},  64'(m00_axis_tlast),  64'(hd[DW]));
    check({tag, ".level"},  64'(fifo_level_out),  64'(mq.size()));
    check({tag, ".ovf"},    64'(overflow_out),    64'(m_ovf));
    check({tag, ".ovfcnt"}, 64'(ovf_count_out),   64'(exp_cnt));
  endtask

  // Called at a negedge: drive inputs, predict, advance one edge, compare at next negedge.
  task automatic step(input string tag, input logic sv, input logic [DW-1:0] d,
                      input logic en, input logic clr, input logic rdy);
    bit pop, req, acc, drop;
    sample_valid_in = sv;
    sample_in       = d;
    enable_in       = en;
    clr_ovf_in      = clr;
    m00_axis_tready = rdy;
    pop  = (mq.size() != 0) && rdy;
    req  = sv && en;
    acc  = req && ((mq.size() < DEPTH) || pop);
    drop = req && !acc;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back({(m_pos == FLEN - 1), d});
      m_pos = (m_pos + 1) % FLEN;
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    rst_in = 1'b1;
    sample_in = '0;
    sample_valid_in = 1'b0;
    enable_in = 1'b0;
    clr_ovf_in = 1'b0;
    m00_axis_tready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset");
    check("tstrb", 64'(m00_axis_tstrb), 64'hF);
    rst_in = 1'b0;

    // Framing: 1..8 back to back with tready high.
    for (int i = 1; i <= 8; i++) step("frame", 1'b1, DW'(i), 1'b1, 1'b0, 1'b1);
    repeat (2) step("frame_drain", 1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Overflow: 20 pushes into a stalled 16-deep FIFO.
    for (int i = 1; i <= 20; i++) step("ovf_fill", 1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    check("ovf_level16", 64'(fifo_level_out), 64'd16);
    check("ovf_flag", 64'(overflow_out), 64'd1);
    // Clear coinciding with another drop: clear wins.
    step("ovf_clr", 1'b1, DW'(99), 1'b1, 1'b1, 1'b0);
    check("clr_flag", 64'(overflow_out), 64'd0);
    check("clr_cnt", 64'(ovf_count_out), 64'd0);
    // Full FIFO with a simultaneous pop still accepts.
    step("full_pop", 1'b1, DW'(17), 1'b1, 1'b0, 1'b1);
    check("full_pop_level", 64'(fifo_level_out), 64'd16);
    for (int i = 0; i < 18; i++) step("ovf_drain", 1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Enable gating: ignored pushes, then resume mid-frame.
    step("en_a", 1'b1, DW'(200), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("en_off", 1'b1, DW'(300 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("en_on", 1'b1, DW'(400 + i), 1'b1, 1'b0, 1'b1);
    repeat (3) step("en_drain", 1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Randomized traffic, including sustained stalls that force drops.
    for (int i = 0; i < 3000; i++) begin
      logic rdy;
      rdy = (i % 400 < 100) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step("rand", ($urandom_range(0, 3) != 0), DW'($urandom()),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 63) == 0), rdy);
    end

    // Mid-frame asynchronous reset between edges.
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, DW'(500 + i), 1'b1, 1'b0, 1'b0);
    #2 rst_in = 1'b1;
    #1;
    check("arst_tvalid", 64'(m00_axis_tvalid), 64'd0);
    check("arst_level", 64'(fifo_level_out), 64'd0);
    check("arst_tlast", 64'(m00_axis_tlast), 64'd0);
    check("arst_ovf", 64'(overflow_out), 64'd0);
    model_reset();
    @(negedge clk);
    rst_in = 1'b0;
    for (int i = 0; i < 6; i++) step("post_rst", 1'b1, DW'(600 + i), 1'b1, 1'b0, 1'b1);
    repeat (2) step("post_rst_drain", 1'b0, '0, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
